rca_4bit: RTL and testbench

RCA_4BIT -- requirements
Module: rca_4bit

---
 rtl/rca_4bit.sv | 69 ++++++
 tb/tb_rca_4bit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rca_4bit.sv
// 4-bit ripple-carry adder with a one-cycle registered result and a valid flag.
// Define RCA_4BIT_OVF_EN to enable the signed-overflow flag; otherwise ovf is tied to 0.

module rca_4bit_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module rca_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  input  logic       in_valid,
  output logic [3:0] s,
  output logic       c_out,
  output logic       ovf,
  output logic       out_valid
);
  // carry[i] feeds cell i; carry[4] is the carry out of bit 3.
  logic [4:0] carry;
  logic [3:0] sum;

  assign carry[0] = c_in;

  for (genvar i = 0; i < 4; i++) begin : g_cell
    rca_4bit_fa u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= '0;
      c_out     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s     <= sum;
        c_out <= carry[4];
      end
    end
  end

`ifdef RCA_4BIT_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= carry[3] ^ carry[4];
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_rca_4bit.sv
// Self-checking bench for rca_4bit: directed corner cases, reset behaviour and all
// 512 operand combinations in random order with random idle gaps.

module tb_rca_4bit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       c_in = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] s;
  logic       c_out;
  logic       ovf;
  logic       out_valid;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference state: last accepted result, held through idle cycles.
  int unsigned exp_s = 0;
  int unsigned exp_c = 0;
  int unsigned exp_ovf = 0;

  rca_4bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .in_valid  (in_valid),
    .s         (s),
    .c_out     (c_out),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Signed overflow from the operand values: same-sign operands whose sum
  // falls outside -8..7 when c_in is counted in.
  function automatic int unsigned ref_ovf(input int unsigned av, input int unsigned bv,
                                          input int unsigned cv);
    int sa, sb, tot;
    sa  = (av >= 8) ? int'(av) - 16 : int'(av);
    sb  = (bv >= 8) ? int'(bv) - 16 : int'(bv);
    tot = sa + sb + int'(cv);
`ifdef RCA_4BIT_OVF_EN
    return (tot > 7 || tot < -8) ? 1 : 0;
`else
    return (tot == tot) ? 0 : 0;
`endif
  endfunction

  task automatic apply(input string tag, input int unsigned av, input int unsigned bv,
                       input int unsigned cv, input bit v);
    int unsigned tot;
    @(negedge clk);
    a = av[3:0]; b = bv[3:0]; c_in = cv[0]; in_valid = v;
    @(posedge clk);
    #1;
    if (v) begin
      tot     = av + bv + cv;
      exp_s   = tot % 16;
      exp_c   = tot / 16;
      exp_ovf = ref_ovf(av, bv, cv);
    end
    check({tag, ".vld"}, 32'(out_valid), 32'(v));
    check({tag, ".s"},   32'(s),         exp_s);
    check({tag, ".c"},   32'(c_out),     exp_c);
    check({tag, ".ovf"}, 32'(ovf),       exp_ovf);
  endtask

  initial begin
    logic [8:0] combo [512];
    int unsigned j;
    logic [8:0] tmp;

    #2;
    check("rst.s",   32'(s),         0);
    check("rst.c",   32'(c_out),     0);
    check("rst.ovf", 32'(ovf),       0);
    check("rst.vld", 32'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    apply("zero",    4'b0000, 4'b0000, 0, 1'b1);
    apply("b2b_1",   4'b1011, 4'b1100, 0, 1'b1);
    check("b2b_1.s_lit", 32'(s), 32'b0111);
    apply("b2b_2",   4'b1111, 4'b0101, 0, 1'b1);
    check("b2b_2.s_lit", 32'(s), 32'b0100);
    apply("ripple",  4'b1111, 4'b0000, 1, 1'b1);
    apply("max",     4'b1111, 4'b1111, 1, 1'b1);
    check("max.c_lit", 32'(c_out), 1);
    apply("hold",    4'b0001, 4'b0001, 0, 1'b0);
    apply("sovf",    4'b0111, 4'b0001, 0, 1'b1);
`ifdef RCA_4BIT_OVF_EN
    check("sovf.lit", 32'(ovf), 1);
`else
    check("sovf.lit", 32'(ovf), 0);
`endif
    apply("negovf",  4'b1000, 4'b1000, 0, 1'b1);

    // Reset asserted between edges while a result is on the outputs.
    apply("pre_rst", 4'b0101, 4'b0110, 1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.s",   32'(s),         0);
    check("arst.c",   32'(c_out),     0);
    check("arst.vld", 32'(out_valid), 0);
    @(negedge clk);
    a = 4'b1111; b = 4'b1111; c_in = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("inrst.s",   32'(s),         0);
    check("inrst.c",   32'(c_out),     0);
    check("inrst.ovf", 32'(ovf),       0);
    check("inrst.vld", 32'(out_valid), 0);
    exp_s = 0; exp_c = 0; exp_ovf = 0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    apply("post_rst", 4'b0011, 4'b0100, 0, 1'b1);
    check("post_rst.lit", 32'(s), 32'b0111);

    for (int i = 0; i < 512; i++) combo[i] = 9'(i);
    for (int i = 511; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = combo[i]; combo[i] = combo[j]; combo[j] = tmp;
    end
    for (int i = 0; i < 512; i++) begin
      if ($urandom_range(3, 0) == 0)
        apply("gap", $urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(1, 0), 1'b0);
      apply("sweep", combo[i][8:5], combo[i][4:1], combo[i][0], 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
